arq_rx_credit_buffer: RTL

Receive-side elastic buffer placed directly downstream of `arq_receiver`. It accepts every delivered payload unconditionally, which guarantees the receiver's `out.valid |-> out.ready` contract. It stores payloads in a FIFO until the consumer takes them. For every entry drained, it returns one credit over a credit-return stream to the upstream credit source that meters `arq_sender` input.

---
 rtl/arq_pkg.sv | 14 +
 rtl/arq_rx_credit_buffer_if.sv | 27 ++
 rtl/arq_rx_credit_buffer_credit_return_accumulator.sv | 65 ++++++
 rtl/arq_rx_credit_buffer.sv | 90 +++++++++
 4 files changed

// File: rtl/arq_pkg.sv
// Shared ARQ receive-path types: credit counter type and credit-return FSM state.
package arq_pkg;

  localparam int unsigned ARQ_DEPTH    = 8;
  localparam int unsigned ARQ_CREDIT_W = $clog2(ARQ_DEPTH + 1);

  typedef logic [ARQ_CREDIT_W-1:0] credit_t;

  typedef enum logic {
    CR_INIT = 1'b0,
    CR_RUN  = 1'b1
  } credit_state_e;

endpackage

// File: rtl/arq_rx_credit_buffer_if.sv
// Payload-in, payload-out and credit-return streams of the receive credit buffer.
// Every stream uses valid/ready: a transfer happens on a rising clk edge where both
// are high; the producer holds its payload stable while valid is high and ready low.
interface arq_rx_credit_buffer_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CREDIT_W = 4
);
  logic                in_valid;
  logic [DATA_W-1:0]   in_payload;
  logic                in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_payload;
  logic                out_ready;
  logic                credit_valid;
  logic [CREDIT_W-1:0] credit_count;
  logic                credit_ready;

  modport master (
    output in_valid, in_payload, out_ready, credit_ready,
    input  in_ready, out_valid, out_payload, credit_valid, credit_count
  );

  modport slave (
    input  in_valid, in_payload, out_ready, credit_ready,
    output in_ready, out_valid, out_payload, credit_valid, credit_count
  );
endinterface

// File: rtl/arq_rx_credit_buffer_credit_return_accumulator.sv
// INIT/RUN credit-return FSM: advertises DEPTH credits once after reset, then
// returns one credit per drained entry, batching while the credit sink stalls.
import arq_pkg::*;

module credit_return_accumulator #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CREDIT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pop_i,
  input  logic                credit_ready_i,
  output logic                credit_valid_o,
  output logic [CREDIT_W-1:0] credit_count_o,
  output credit_state_e       state_o
);

  credit_state_e       state_q, state_d;
  logic [CREDIT_W-1:0] pending_q, pending_d;
  logic                handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CR_INIT;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Pops during INIT keep accumulating; only a RUN handshake hands pending over.
  always_comb begin
    handshake = credit_valid_o && credit_ready_i;
    state_d   = state_q;
    pending_d = pending_q + CREDIT_W'(pop_i);
    case (state_q)
      CR_INIT: if (handshake) state_d = CR_RUN;
      CR_RUN:  if (handshake) pending_d = CREDIT_W'(pop_i);
      default: state_d = CR_INIT;
    endcase
  end

  // Outputs are forced low while reset is held so INIT is seen only after release.
  always_comb begin
    credit_valid_o = 1'b0;
    credit_count_o = '0;
    if (rst_n) begin
      case (state_q)
        CR_INIT: begin
          credit_valid_o = 1'b1;
          credit_count_o = CREDIT_W'(DEPTH);
        end
        CR_RUN: begin
          credit_valid_o = (pending_q != '0);
          credit_count_o = pending_q;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/arq_rx_credit_buffer.sv
// Receive elastic buffer: always accepts payloads, queues them in a ring FIFO and
// returns one credit per drained entry. ARQ_RX_CREDIT_BUFFER_BYPASS_EN enables empty-FIFO bypass.
import arq_pkg::*;

module arq_rx_credit_buffer #(
  parameter  int unsigned DEPTH    = 8,
  parameter  int unsigned DATA_W   = 32,
  localparam int unsigned CREDIT_W = $clog2(DEPTH + 1),
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arq_rx_credit_buffer_if.slave bus,
  output logic [CREDIT_W-1:0]   level,
  output logic                  overflow,
  output credit_state_e         dbg_credit_state_o
);

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CREDIT_W-1:0] level_q, level_d;
  logic                overflow_q;
  logic                full, not_empty, pop, fifo_pop, wr_en;

  assign full      = (level_q == CREDIT_W'(DEPTH));
  assign not_empty = (level_q != '0);

`ifdef ARQ_RX_CREDIT_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass          = !not_empty && bus.in_valid;
  assign bus.out_valid   = not_empty || bypass;
  assign bus.out_payload = not_empty ? mem_q[rd_ptr_q] :
                           (bypass ? bus.in_payload : '0);
  // A bypassed beat that is consumed immediately never touches storage.
  assign wr_en           = bus.in_valid && !(full && !pop) && !(bypass && bus.out_ready);
`else
  assign bus.out_valid   = not_empty;
  assign bus.out_payload = not_empty ? mem_q[rd_ptr_q] : '0;
  assign wr_en           = bus.in_valid && !(full && !pop);
`endif

  assign bus.in_ready = rst_n;
  assign pop          = bus.out_valid && bus.out_ready;
  assign fifo_pop     = pop && not_empty;

  always_comb begin
    level_d = level_q;
    if (wr_en && !fifo_pop)      level_d = level_q + CREDIT_W'(1);
    else if (!wr_en && fifo_pop) level_d = level_q - CREDIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.in_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      if (bus.in_valid && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;

  credit_return_accumulator #(
    .DEPTH    (DEPTH),
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .clk            (clk),
    .rst_n          (rst_n),
    .pop_i          (pop),
    .credit_ready_i (bus.credit_ready),
    .credit_valid_o (bus.credit_valid),
    .credit_count_o (bus.credit_count),
    .state_o        (dbg_credit_state_o)
  );

endmodule
